// File: rtl/result_accumulator.sv
// Accumulates N valid 4-bit samples from the upstream arithmetic stage and
// reports running sum, min, max and a sticky overflow, with a done pulse per run.
module result_accumulator #(
   parameter int COUNT_W = 4,
   parameter int SUM_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] sample_count,
   input  logic [3:0]         in_data,
   input  logic               in_valid,
   output logic               busy,
   output logic               done,
   output logic [SUM_W-1:0]   sum,
   output logic [3:0]         min_val,
   output logic [3:0]         max_val,
   output logic               overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [COUNT_W-1:0] target_q;
   logic [COUNT_W-1:0] count_q;
   logic [SUM_W-1:0]   sum_q;
   logic [3:0]         min_q;
   logic [3:0]         max_q;
   logic               ovf_q;
   logic               busy_q;
   logic               done_q;

   logic [SUM_W:0]     add_d;
   logic [COUNT_W-1:0] count_d;
   logic               last_d;

   // Extra top bit of the adder is the carry-out feeding the sticky overflow.
   assign add_d   = {1'b0, sum_q} + (SUM_W + 1)'(in_data);
   assign count_d = count_q + 1'b1;
   assign last_d  = (count_d == target_q);

   // NOTE: every register here uses <= so all of them sample pre-edge values;
   // a blocking = would let later statements see this cycle's updates.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         target_q <= '0;
         count_q  <= '0;
         sum_q    <= '0;
         min_q    <= '0;
         max_q    <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (sample_count != '0)) begin
                  target_q <= sample_count;
                  count_q  <= '0;
                  sum_q    <= '0;
                  min_q    <= 4'hF;
                  max_q    <= 4'h0;
                  ovf_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (in_valid) begin
                  sum_q   <= add_d[SUM_W-1:0];
                  ovf_q   <= ovf_q | add_d[SUM_W];
                  count_q <= count_d;
                  if (in_data < min_q) min_q <= in_data;
                  if (in_data > max_q) max_q <= in_data;
                  if (last_d) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign min_val  = min_q;
   assign max_val  = max_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_result_accumulator.sv
// Bench for result_accumulator: two instances (SUM_W=8 and SUM_W=4) share stimulus
// and are checked every cycle against a queue-based model of the accepted samples.
module tb_result_accumulator;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] sample_count = '0;
   logic [3:0] in_data = '0;
   logic       in_valid = 1'b0;

   logic       busy8, done8, ovf8;
   logic [7:0] sum8;
   logic [3:0] min8, max8;
   logic       busy4, done4, ovf4;
   logic [3:0] sum4;
   logic [3:0] min4, max4;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clock = ~clock;

   result_accumulator #(.COUNT_W(4), .SUM_W(8)) dut8 (
      .clock(clock), .reset(reset), .start(start), .sample_count(sample_count),
      .in_data(in_data), .in_valid(in_valid), .busy(busy8), .done(done8),
      .sum(sum8), .min_val(min8), .max_val(max8), .overflow(ovf8)
   );

   result_accumulator #(.COUNT_W(4), .SUM_W(4)) dut4 (
      .clock(clock), .reset(reset), .start(start), .sample_count(sample_count),
      .in_data(in_data), .in_valid(in_valid), .busy(busy4), .done(done4),
      .sum(sum4), .min_val(min4), .max_val(max4), .overflow(ovf4)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0=idle 1=accumulating 2=done; results derive from the list
   // of samples accepted in the current run.
   int m_phase = 0;
   int m_n = 0;
   bit m_have = 1'b0;
   int m_q[$];

   always @(posedge clock) begin
      if (reset) begin
         m_phase = 0;
         m_have  = 1'b0;
         m_q.delete();
      end else begin
         case (m_phase)
            0: if (start && sample_count != 0) begin
                  m_n = sample_count;
                  m_q.delete();
                  m_have  = 1'b1;
                  m_phase = 1;
               end
            1: if (in_valid) begin
                  m_q.push_back(int'(in_data));
                  if (m_q.size() == m_n) m_phase = 2;
               end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clock) begin
      int total, emin, emax;
      if (cmp_en) begin
         total = 0;
         emin  = m_have ? 15 : 0;
         emax  = 0;
         foreach (m_q[i]) begin
            total += m_q[i];
            if (m_q[i] < emin) emin = m_q[i];
            if (m_q[i] > emax) emax = m_q[i];
         end
         check("busy8", busy8, m_phase != 0);
         check("done8", done8, m_phase == 2);
         check("sum8",  sum8,  total % 256);
         check("ovf8",  ovf8,  total >= 256);
         check("min8",  min8,  emin);
         check("max8",  max8,  emax);
         check("busy4", busy4, m_phase != 0);
         check("done4", done4, m_phase == 2);
         check("sum4",  sum4,  total % 16);
         check("ovf4",  ovf4,  total >= 16);
         check("min4",  min4,  emin);
         check("max4",  max4,  emax);
      end
   end

   task automatic cyc(input bit r, input bit s, input logic [3:0] n,
                      input bit v, input logic [3:0] d);
      @(negedge clock);
      reset        = r;
      start        = s;
      sample_count = n;
      in_valid     = v;
      in_data      = d;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic random_run();
      int guard;
      logic [3:0] n;
      n = 4'($urandom_range(1, 15));
      cyc(0, 1, n, $urandom_range(0, 1), 4'($urandom));
      guard = 0;
      do begin
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, 4'($urandom),
             $urandom_range(0, 3) != 0, 4'($urandom));
         guard++;
      end while (m_phase != 0 && guard < 200);
      check("run_completes", guard < 200, 1);
   endtask

   initial begin
      // Reset held two cycles with random inputs.
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         start = $urandom_range(0, 1); sample_count = 4'($urandom);
         in_valid = $urandom_range(0, 1); in_data = 4'($urandom);
         if (i == 0) cmp_en = 1'b1;
      end
      cyc(0, 0, 0, 1, 9);
      check("rst_sum", sum8, 0);
      check("rst_busy", busy8, 0);
      cyc(0, 0, 0, 1, 3);
      cyc(0, 0, 0, 0, 0);
      check("novalid_sum", sum8, 0);
      check("novalid_max", max8, 0);

      // Contiguous run; sample in the start cycle is not counted.
      cyc(0, 1, 4, 1, 11);
      cyc(0, 0, 0, 1, 3);
      cyc(0, 0, 0, 1, 9);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 15);
      cyc(0, 0, 0, 0, 0);
      check("c_done", done8, 1);
      check("c_sum", sum8, 27);
      check("c_min", min8, 0);
      check("c_max", max8, 15);
      check("c_ovf", ovf8, 0);
      cyc(0, 0, 0, 0, 0);
      check("c_busy_drop", busy8, 0);
      check("c_done_drop", done8, 0);

      // Gapped run with a start pulse mid-run.
      cyc(0, 1, 3, 0, 0);
      cyc(0, 0, 0, 1, 5);
      cyc(0, 1, 1, 0, 15);
      cyc(0, 0, 0, 0, 15);
      cyc(0, 0, 0, 1, 7);
      cyc(0, 0, 0, 1, 2);
      cyc(0, 0, 0, 0, 0);
      check("g_done", done8, 1);
      check("g_sum", sum8, 14);
      check("g_min", min8, 2);
      check("g_max", max8, 7);
      idle(1);

      // Start with N=0 is ignored.
      cyc(0, 1, 0, 1, 4);
      cyc(0, 0, 0, 0, 0);
      check("n0_busy", busy8, 0);
      check("n0_sum", sum8, 14);

      // Overflow at SUM_W=4, then cleared by the next run.
      cyc(0, 1, 3, 0, 0);
      cyc(0, 0, 0, 1, 8);
      cyc(0, 0, 0, 1, 8);
      cyc(0, 0, 0, 1, 3);
      cyc(0, 0, 0, 0, 0);
      check("o_sum4", sum4, 3);
      check("o_ovf4", ovf4, 1);
      check("o_sum8", sum8, 19);
      check("o_ovf8", ovf8, 0);
      idle(1);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0);
      check("o2_sum4", sum4, 1);
      check("o2_ovf4", ovf4, 0);
      idle(1);

      // Reset mid-run discards the partial run.
      cyc(0, 1, 4, 0, 0);
      cyc(0, 0, 0, 1, 6);
      cyc(0, 0, 0, 1, 10);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 4);
      check("r_sum", sum8, 0);
      check("r_busy", busy8, 0);
      check("r_min", min8, 0);
      cyc(0, 0, 0, 1, 5);
      cyc(0, 0, 0, 0, 0);
      check("r_nodone", done8, 0);
      check("r_sum_after", sum8, 0);

      for (int i = 0; i < 40; i++) begin
         random_run();
         idle($urandom_range(0, 2));
      end

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
